// File: rtl/systolic_psum_drain_pkg.sv
// rtl/systolic_psum_drain_pkg.sv - shared constants, drain state enum and bus-slice helper
package systolic_pkg;

    localparam int SUM_WIDTH  = 32;
    localparam int COLS       = 8;
    localparam int GROUP_COLS = 4;
    localparam int NUM_GROUPS = COLS / GROUP_COLS;
    localparam int COL_W      = $clog2(COLS);
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int BUS_W      = GROUP_COLS * SUM_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SEL0   = 3'd2,
        S_CAP0   = 3'd3,
        S_SEL1   = 3'd4,
        S_CAP1   = 3'd5,
        S_STREAM = 3'd6
    } drain_state_e;

    // Slot k of the banked array port occupies bits [k*SUM_WIDTH +: SUM_WIDTH].
    function automatic logic [SUM_WIDTH-1:0] bus_slice(input logic [BUS_W-1:0] bus, input int slot);
        return bus[slot*SUM_WIDTH +: SUM_WIDTH];
    endfunction

endpackage

// File: rtl/systolic_psum_drain_if.sv
// rtl/systolic_psum_drain_if.sv - control, array-bank and output-stream signals of the drain
interface systolic_psum_drain_if;
    import systolic_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 output_group_sel;
    logic [BUS_W-1:0]     psum_out_bus;
    logic                 m_valid;
    logic                 m_ready;
    logic [SUM_WIDTH-1:0] m_data;
    logic [COL_W-1:0]     m_col;
    logic                 m_last;

    modport master (
        input  start,
        input  psum_out_bus,
        input  m_ready,
        output busy,
        output done,
        output output_group_sel,
        output m_valid,
        output m_data,
        output m_col,
        output m_last
    );

    modport slave (
        output start,
        output psum_out_bus,
        output m_ready,
        input  busy,
        input  done,
        input  output_group_sel,
        input  m_valid,
        input  m_data,
        input  m_col,
        input  m_last
    );

endinterface

// File: rtl/systolic_psum_drain_col_buffer.sv
// rtl/systolic_psum_drain_col_buffer.sv - COLS x SUM_WIDTH register file, group write, column read
module psum_col_buffer
    import systolic_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_en,
    input  logic [GRP_W-1:0]     i_wr_grp,
    input  logic [BUS_W-1:0]     i_wr_bus,
    input  logic [COL_W-1:0]     i_rd_col,
    output logic [SUM_WIDTH-1:0] o_rd_data
);

    logic [SUM_WIDTH-1:0] r_mem [COLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                r_mem[c] <= '0;
            end
        end else if (i_wr_en) begin
            for (int c = 0; c < COLS; c++) begin
                if ((c / GROUP_COLS) == int'(i_wr_grp)) begin
                    r_mem[c] <= bus_slice(i_wr_bus, c % GROUP_COLS);
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_col];

endmodule

// File: rtl/systolic_psum_drain.sv
// rtl/systolic_psum_drain.sv - waits out array latency, captures both column groups, streams COLS sums
module systolic_psum_drain
    import systolic_pkg::*;
#(
    parameter int LATENCY = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    systolic_psum_drain_if.master drain
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    drain_state_e         r_state;
    drain_state_e         w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [COL_W-1:0]     r_col;
    logic                 r_sel;
    logic                 r_done;
    logic                 w_hs;
    logic                 w_last_col;
    logic                 w_wr_en;
    logic [GRP_W-1:0]     w_wr_grp;
    logic [SUM_WIDTH-1:0] w_rd_data;

    assign w_hs       = (r_state == S_STREAM) && drain.m_ready;
    assign w_last_col = (r_col == COL_W'(COLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (drain.start) begin
                    w_next = (LATENCY == 0) ? S_SEL0 : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_SEL0;
                end
            end
            S_SEL0:   w_next = S_CAP0;
            S_CAP0:   w_next = S_SEL1;
            S_SEL1:   w_next = S_CAP1;
            S_CAP1:   w_next = S_STREAM;
            S_STREAM: begin
                if (w_hs && w_last_col) begin
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // The group select flips one cycle ahead of each capture so the array bus can settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_col  <= '0;
            r_sel  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && drain.start) begin
                r_cnt <= LAT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_next == S_SEL0) begin
                r_sel <= 1'b0;
            end else if (w_next == S_SEL1) begin
                r_sel <= 1'b1;
            end

            if (r_state == S_CAP1) begin
                r_col <= '0;
            end else if (w_hs) begin
                r_col <= r_col + 1'b1;
            end

            r_done <= w_hs && w_last_col;
        end
    end

    assign w_wr_en  = (r_state == S_CAP0) || (r_state == S_CAP1);
    assign w_wr_grp = GRP_W'(r_state == S_CAP1);

    psum_col_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_grp  (w_wr_grp),
        .i_wr_bus  (drain.psum_out_bus),
        .i_rd_col  (r_col),
        .o_rd_data (w_rd_data)
    );

    assign drain.busy             = (r_state != S_IDLE);
    assign drain.done             = r_done;
    assign drain.output_group_sel = r_sel;
    assign drain.m_valid          = (r_state == S_STREAM);
    assign drain.m_data           = (r_state == S_STREAM) ? w_rd_data : '0;
    assign drain.m_col            = r_col;
    assign drain.m_last           = (r_state == S_STREAM) && w_last_col;

endmodule

// File: tb/tb_systolic_psum_drain.sv
// tb/tb_systolic_psum_drain.sv - directed bench with beat scoreboard for LATENCY=25 and LATENCY=0 builds
module tb_systolic_psum_drain;
    import systolic_pkg::*;

    localparam int LAT_A = 25;
    localparam int LAT_B = 0;

    typedef struct packed {
        logic [2:0]  col;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_psum_drain_if if_a ();
    systolic_psum_drain_if if_b ();

    systolic_psum_drain #(.LATENCY(LAT_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .drain(if_a));
    systolic_psum_drain #(.LATENCY(LAT_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .drain(if_b));

    int    n_total = 0;
    int    n_bad   = 0;
    beat_t sb[$];
    beat_t mon_e;

    logic [1:0]  t_start = '0;
    logic [1:0]  t_ready = '0;
    logic        force_ones = 1'b1;
    logic [31:0] mvals [2][8];
    bit          pat [11] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1};

    logic [1:0]  s_valid, s_last, s_done, s_busy, s_sel;
    logic [31:0] s_data [2];
    logic [2:0]  s_col  [2];
    logic [1:0]  psel = '0;
    logic [BUS_W-1:0] bus_a, bus_b;

    assign if_a.start   = t_start[0];
    assign if_b.start   = t_start[1];
    assign if_a.m_ready = t_ready[0];
    assign if_b.m_ready = t_ready[1];
    assign s_valid = {if_b.m_valid, if_a.m_valid};
    assign s_last  = {if_b.m_last, if_a.m_last};
    assign s_done  = {if_b.done, if_a.done};
    assign s_busy  = {if_b.busy, if_a.busy};
    assign s_sel   = {if_b.output_group_sel, if_a.output_group_sel};
    assign s_data[0] = if_a.m_data;
    assign s_data[1] = if_b.m_data;
    assign s_col[0]  = if_a.m_col;
    assign s_col[1]  = if_b.m_col;

    // Array model: garbage on every slot in the cycle right after the group select changes.
    always @(posedge clk) psel <= s_sel;

    always_comb begin
        bus_a = '0;
        bus_b = '0;
        for (int k = 0; k < GROUP_COLS; k++) begin
            bus_a[k*32 +: 32] = force_ones ? 32'hFFFF_FFFF :
                                (s_sel[0] != psel[0]) ? 32'hDEAD_BEEF : mvals[0][{s_sel[0], 2'(k)}];
            bus_b[k*32 +: 32] = force_ones ? 32'hFFFF_FFFF :
                                (s_sel[1] != psel[1]) ? 32'hDEAD_BEEF : mvals[1][{s_sel[1], 2'(k)}];
        end
    end

    assign if_a.psum_out_bus = bus_a;
    assign if_b.psum_out_bus = bus_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int id);
        chk("rst_busy",  s_busy[id],  0);
        chk("rst_sel",   s_sel[id],   0);
        chk("rst_valid", s_valid[id], 0);
        chk("rst_data",  s_data[id],  0);
        chk("rst_col",   s_col[id],   0);
        chk("rst_last",  s_last[id],  0);
        chk("rst_done",  s_done[id],  0);
    endtask

    task automatic push8(input int id);
        beat_t e;
        for (int c = 0; c < COLS; c++) begin
            e.col  = 3'(c);
            e.data = mvals[id][c];
            e.last = (c == COLS - 1);
            sb.push_back(e);
        end
    endtask

    int beats [2] = '{0, 0};
    int dones [2] = '{0, 0};
    logic [1:0]  p_stall  = '0;
    logic [1:0]  p_hslast = '0;
    logic [31:0] p_data [2];
    logic [2:0]  p_col  [2];

    // Stream monitor: scoreboard pop on handshake, stability while stalled, done ordering.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int id = 0; id < 2; id++) begin
                if (p_stall[id]) begin
                    chk("stall_valid", s_valid[id], 1);
                    chk("stall_data",  s_data[id],  p_data[id]);
                    chk("stall_col",   s_col[id],   p_col[id]);
                end
                if (s_valid[id] && t_ready[id]) begin
                    chk("beat_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        chk("beat_col",  s_col[id],  mon_e.col);
                        chk("beat_data", s_data[id], mon_e.data);
                        chk("beat_last", s_last[id], mon_e.last);
                    end
                    beats[id] <= beats[id] + 1;
                end
                if (s_done[id]) begin
                    chk("done_after_last", p_hslast[id], 1);
                    dones[id] <= dones[id] + 1;
                end
                p_stall[id]  <= s_valid[id] && !t_ready[id];
                p_hslast[id] <= s_valid[id] && t_ready[id] && s_last[id];
                p_data[id]   <= s_data[id];
                p_col[id]    <= s_col[id];
            end
        end else begin
            p_stall  <= '0;
            p_hslast <= '0;
        end
    end

    task automatic run_drain(input int id, input int lat, input bit bp, input bit chain,
                             input bit pre, input int restart_at, input int abort_at);
        int k, first, dk, b0, d0;
        bit aborted;
        b0 = beats[id];
        d0 = dones[id];
        if (!pre) begin
            push8(id);
            t_start[id] = 1'b1;
        end
        @(posedge clk); #1;
        t_start[id] = 1'b0;
        first   = -1;
        dk      = -1;
        aborted = 1'b0;
        for (k = 0; k < 400; k++) begin
            t_ready[id] = bp ? pat[k % 11] : 1'b1;
            t_start[id] = (k == restart_at);
            if (k == abort_at) begin
                rst_n = 1'b0;
                sb.delete();
                @(negedge clk);
                chk_reset(id);
                @(posedge clk); #1;
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            if (k == 0) chk("busy_after_start", s_busy[id], 1);
            if (first < 0 && s_valid[id]) first = k;
            if (s_done[id]) begin
                dk = k;
                chk("busy_low_at_done", s_busy[id], 0);
                if (chain) begin
                    push8(id);
                    t_start[id] = 1'b1;
                end
                break;
            end
            @(posedge clk); #1;
        end
        if (!aborted) begin
            chk("done_seen", dk >= 0, 1);
            if (!bp) begin
                chk("first_valid_cycle", first, lat + 4);
                chk("done_cycle", dk, lat + 4 + COLS);
            end
            #1;
            if (!chain) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("done_single_cycle", s_done[id], 0);
                @(posedge clk); #1;
            end
            chk("beat_count", beats[id] - b0, COLS);
            chk("done_count", dones[id] - d0, 1);
            chk("sb_left", sb.size(), chain ? COLS : 0);
        end
    endtask

    initial begin
        for (int c = 0; c < COLS; c++) begin
            mvals[0][c] = 32'(1160 + 1000 * c);
            mvals[1][c] = 32'(1160 + 1000 * c);
        end

        // Reset held two cycles with an all-ones array bus
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        force_ones = 1'b0;
        @(negedge clk);
        chk_reset(0);
        @(posedge clk); #1;

        // Basic drain, sel starts at 0 so only the SEL1 cycle sees garbage
        run_drain(0, LAT_A, 1'b0, 1'b0, 1'b0, -1, -1);

        // Backpressure; sel returns from 1 to 0 so the SEL0 cycle sees garbage
        for (int c = 0; c < COLS; c++) mvals[0][c] = 32'h1000_0000 + 32'(c) * 32'h0011_0011;
        run_drain(0, LAT_A, 1'b1, 1'b0, 1'b0, -1, -1);

        // Repeated start in WAIT must not restart the latency
        for (int c = 0; c < COLS; c++) mvals[0][c] = 32'hA000_0000 | 32'(c);
        run_drain(0, LAT_A, 1'b0, 1'b0, 1'b0, 5, -1);

        // Reset mid-WAIT, then a fresh drain with new values
        run_drain(0, LAT_A, 1'b0, 1'b0, 1'b0, -1, 10);
        @(negedge clk);
        chk_reset(0);
        @(posedge clk); #1;
        for (int c = 0; c < COLS; c++) mvals[0][c] = 32'h5555_0000 + 32'(c * 7);
        run_drain(0, LAT_A, 1'b0, 1'b0, 1'b0, -1, -1);

        // Zero-latency build, second start issued in the done cycle
        run_drain(1, LAT_B, 1'b0, 1'b1, 1'b0, -1, -1);
        run_drain(1, LAT_B, 1'b0, 1'b0, 1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_psum_drain.md
# systolic_psum_drain

Output-side reader for the systolic array's banked partial-sum port. On a `start` pulse it waits a fixed pipeline latency, then drives `output_group_sel` through both column groups and captures each 4-column slice of `psum_out_bus` into a local buffer. It then serializes all `COLS` column sums one per beat on a valid/ready stream toward the accumulation/writeback path. It takes over the output-bank sequencing that the array benches currently perform by hand.

## Interface
- `COLS`, 8, array column count; must equal `2*GROUP_COLS`.
- `GROUP_COLS`, 4, columns presented per `output_group_sel` setting.
- `SUM_WIDTH`, 32, width of one column sum.
- `LATENCY`, 25, cycles from accepted `start` until array sums are stable; 0 is legal.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to drain; sampled only in IDLE.
- `busy`  out  1  high from the accepted `start` until the final handshake.
- `output_group_sel`  out  1  registered; selects array column group (0 = cols 0..3, 1 = cols 4..7).
- `psum_out_bus`  in  `GROUP_COLS*SUM_WIDTH`  array output; slot k occupies bits `[k*SUM_WIDTH +: SUM_WIDTH]`.
- `m_valid`  out  1  stream beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  `SUM_WIDTH`  column sum.
- `m_col`  out  `$clog2(COLS)`  column index of the current beat.
- `m_last`  out  1  high on the beat carrying column `COLS-1`.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- States: IDLE, WAIT, SEL0, CAP0, SEL1, CAP1, STREAM.
- **IDLE**
  - `start` = 1 → WAIT, or → SEL0 if `LATENCY` = 0.
  - Load the latency counter with `LATENCY-1`.
- **WAIT**
  - Count down each cycle.
  - At count 0 → SEL0.
- **SEL0**
  - `output_group_sel` = 0 during this cycle; the bus is settling and is not sampled.
  - → CAP0.
- **CAP0**
  - On the edge ending this state, capture slot k into `buf[k]`, k = 0..3.
  - → SEL1.
- **SEL1**
  - `output_group_sel` = 1; no capture.
  - → CAP1.
- **CAP1**
  - Capture slot k into `buf[k+4]`.
  - → STREAM with column index 0.
- **STREAM**
  - `m_valid` = 1.
  - `m_data` = `buf[m_col]`.
  - On `m_valid && m_ready`: increment `m_col`.
  - On the handshake of column `COLS-1`: → IDLE and pulse `done` in the next cycle.
- Captured values are copied verbatim; there is no arithmetic and no saturation.
- `output_group_sel` holds its last value in IDLE, STREAM and WAIT.

## Timing
- Reset values: `busy` = 0, `output_group_sel` = 0, `m_valid` = 0, `m_data` = 0, `m_col` = 0, `m_last` = 0, `done` = 0, all buffer entries 0, state IDLE.
- Reset mid-operation returns immediately to the reset values. A partially streamed drain is discarded and is not resumed.
- `start` accepted at edge E0:
  - `busy` = 1 after E0.
  - The first `m_valid` appears after edge E0 + `LATENCY` + 4.
- With `m_ready` held high:
  - The last beat is accepted at E0 + `LATENCY` + 4 + `COLS`.
  - `done` is high during the following cycle.
  - `busy` is low from that same edge.
- Backpressure:
  - While `m_valid && !m_ready`, `m_data`, `m_col` and `m_last` hold stable.
  - `m_valid` never drops before the handshake.
- Ignored requests:
  - `start` while `busy` is ignored, including the cycle of the final handshake.
  - `start` in the `done` cycle is accepted, since the state is already IDLE.
- `m_ready` is ignored outside STREAM.

## Structure
- Shared package `systolic_pkg` holds:
  - `SUM_WIDTH`, `COLS`, `GROUP_COLS`.
  - The drain state enum.
  - The bus-slice helper function.
- One sub-module: `psum_col_buffer`, a `COLS`×`SUM_WIDTH` register file.
  - Writes one group per cycle via a group-index input.
  - Reads one column combinationally.
- The FSM, latency counter and column counter live in the top module.

## Test plan
- **Reset:** assert `rst_n` = 0 for 2 cycles → every output at its listed reset value, with `psum_out_bus` = all-ones.
- **Basic drain:**
  - Stimulus:
    - The array model returns 1160, 2160, 3160, 4160 when sel = 0.
    - It returns 5160, 6160, 7160, 8160 when sel = 1.
    - `m_ready` = 1; `start` pulsed.
  - Response:
    - First `m_valid` after edge `LATENCY`+4.
    - Beats are cols 0..7 carrying 1160…8160 in order.
    - `m_last` is set only on col 7.
    - `done` pulses once.
- **Bank switch settling:**
  - Stimulus: the model drives 0xDEADBEEF in every slot during any cycle in which sel changed on the previous edge.
  - Response: no 0xDEADBEEF is ever streamed, and the correct group values are captured.
- **Backpressure:**
  - Stimulus: `m_ready` pattern 1,0,0,1,0,1,1,0,1,1,1.
  - Response:
    - `m_data` and `m_col` are stable during each stall.
    - Exactly 8 beats, with no duplicate and no skip.
    - `done` only after the col-7 handshake.
- **Reset and re-start:**
  - Stimulus: `start` repeated during WAIT, then `rst_n` pulsed low mid-WAIT, then a fresh `start`.
  - Response:
    - The repeated `start` is ignored and the latency is not restarted.
    - After reset the outputs match the reset values.
    - The fresh drain completes with correct values.
- **Zero latency:**
  - Stimulus: `LATENCY` = 0 build.
  - Response:
    - First `m_valid` after edge E0+4.
    - Back-to-back `start` in the `done` cycle is accepted and produces a second full 8-beat drain.
